// File: rtl/sqrt_pkg.sv
// Shared types and widths for the sequential integer square-root unit.
// The remainder output is enabled by defining SQRT_REM_OUT_EN.
package sqrt_pkg;

    localparam int SUB_W     = 16;
    localparam int RAD_W_DEF = 16;
    localparam int ROOT_W    = RAD_W_DEF / 2;
    localparam int REM_W     = RAD_W_DEF / 2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sqrt_state_e;

endpackage

// File: rtl/sqrt_seq_ctrl_fs.sv
// 16-bit ripple-borrow full subtractor shared by every trial step of the
// square-root iteration; borrow-out c is the "sh < trial" compare result.
module FS_16bit
    import sqrt_pkg::*;
(
    input  logic [SUB_W-1:0] a,
    input  logic [SUB_W-1:0] b,
    input  logic             b_in,
    output logic [SUB_W-1:0] diff,
    output logic             c
);

    // Bit-serial borrow ripple from LSB to MSB.
    always_comb begin
        logic bw;
        bw   = b_in;
        diff = {SUB_W{1'b0}};
        for (int i = 0; i < SUB_W; i++) begin
            diff[i] = a[i] ^ b[i] ^ bw;
            bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        c = bw;
    end

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// Restoring digit-by-digit integer square root, one trial subtraction per
// cycle through a shared FS_16bit. Define SQRT_REM_OUT_EN to expose out_rem.
module sqrt_seq_ctrl
    import sqrt_pkg::*;
#(
    parameter int RAD_W = RAD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RAD_W-1:0]   in_rad,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RAD_W/2-1:0] out_root
`ifdef SQRT_REM_OUT_EN
    ,
    output logic [RAD_W/2:0]   out_rem
`endif
);

    localparam int R_W   = RAD_W / 2;
    localparam int M_W   = R_W + 1;
    localparam int SH_W  = R_W + 3;
    localparam int TR_W  = R_W + 2;
    localparam int CNT_W = 4;

    sqrt_state_e      state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [RAD_W-1:0] rad_r;
    logic [R_W-1:0]   root_r;
    logic [M_W-1:0]   rem_r;
    logic [R_W-1:0]   out_root_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [SH_W-1:0]  sh_s;
    logic [TR_W-1:0]  trial_s;
    logic [SUB_W-1:0] sub_a_s;
    logic [SUB_W-1:0] sub_b_s;
    logic [SUB_W-1:0] diff_s;
    logic             borrow_s;
    logic [R_W-1:0]   root_nx_s;
    logic [M_W-1:0]   rem_nx_s;
    logic             last_s;
    logic             unused_diff_s;

    assign sh_s      = {rem_r, rad_r[RAD_W-1 -: 2]};
    assign trial_s   = {root_r, 2'b01};
    assign sub_a_s   = {{(SUB_W-SH_W){1'b0}}, sh_s};
    assign sub_b_s   = {{(SUB_W-TR_W){1'b0}}, trial_s};

    FS_16bit u_fs (
        .a    (sub_a_s),
        .b    (sub_b_s),
        .b_in (1'b0),
        .diff (diff_s),
        .c    (borrow_s)
    );

    // rem never exceeds 2*root, so only the low M_W difference bits matter.
    assign root_nx_s     = R_W'({root_r, ~borrow_s});
    assign rem_nx_s      = borrow_s ? sh_s[M_W-1:0] : diff_s[M_W-1:0];
    assign unused_diff_s = ^diff_s[SUB_W-1:M_W];
    assign last_s        = (cnt_r == CNT_W'(R_W - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic for the accept / iterate / hold-result sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Handshake flags registered from the next state, so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Iteration datapath: radicand shifter, partial root, partial remainder, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_r  <= {RAD_W{1'b0}};
            root_r <= {R_W{1'b0}};
            rem_r  <= {M_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        rad_r  <= in_rad;
                        root_r <= {R_W{1'b0}};
                        rem_r  <= {M_W{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    rad_r  <= rad_r << 2'd2;
                    root_r <= root_nx_s;
                    rem_r  <= rem_nx_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers only load on the final iteration, hiding partial values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_root_r <= {R_W{1'b0}};
        end else if ((state_r == ST_CALC) && last_s) begin
            out_root_r <= root_nx_s;
        end
    end

`ifdef SQRT_REM_OUT_EN
    logic [M_W-1:0] out_rem_r;

    // Final remainder captured alongside the root.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rem_r <= {M_W{1'b0}};
        end else if ((state_r == ST_CALC) && last_s) begin
            out_rem_r <= rem_nx_s;
        end
    end

    assign out_rem = out_rem_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_root  = out_root_r;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Randomized self-checking bench for sqrt_seq_ctrl against an arithmetic
// square-root model; remainder checks apply when SQRT_REM_OUT_EN is defined.
module tb_sqrt_seq_ctrl;
    import sqrt_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_rad;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] out_root;
`ifdef SQRT_REM_OUT_EN
    logic [REM_W-1:0]  out_rem;
`endif

    int vectors;
    int miscompares;
    int cyc;

    sqrt_seq_ctrl #(.RAD_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rad    (in_rad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root)
`ifdef SQRT_REM_OUT_EN
        ,
        .out_rem   (out_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input int unsigned rad);
        int unsigned er;
        er = isqrt(rad);
        check_val("root", 32'(out_root), er);
`ifdef SQRT_REM_OUT_EN
        check_val("rem", 32'(out_rem), rad - er * er);
`endif
    endtask

    // One transaction from IDLE: accept, measure latency, hold result `hold` cycles, hand off.
    task automatic run_op(input logic [15:0] rad, input int hold);
        int lat;
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_rad    = rad;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_rad    = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'd8);
        check_result(32'(rad));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_rad   = 16'($urandom);
            @(negedge clk);
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_result(32'(rad));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("handoff_in_ready", 32'(in_ready), 32'd1);
        check_val("handoff_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] b2b [3];
        int          t_acc [3];
        int          w;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_rad      = 16'd0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_root", 32'(out_root), 32'd0);
`ifdef SQRT_REM_OUT_EN
        check_val("rst_rem", 32'(out_rem), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd0, 0);
        run_op(16'd144, 1);
        run_op(16'd1, 0);
        run_op(16'd65535, 2);
        run_op(16'd65024, 0);
        run_op(16'd200, 5);

        // Abort part-way through the iterations of 50000.
        in_rad   = 16'd50000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_root", 32'(out_root), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_abort_valid", 32'(out_valid), 32'd0);
        run_op(16'd81, 0);

        // Back-to-back stream with the consumer always ready.
        b2b[0] = 16'd16;
        b2b[1] = 16'd17;
        b2b[2] = 16'd99;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            t_acc[k] = cyc;
            in_rad   = b2b[k];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            w = 0;
            while (!out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            check_val("b2b_latency", 32'(w), 32'd8);
            check_result(32'(b2b[k]));
            if (k > 0) check_val("b2b_ii", 32'(t_acc[k] - t_acc[k-1]), 32'd10);
        end
        @(negedge clk);
        out_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            run_op(16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
